alu_mc: RTL and testbench

- Parametrised next-generation integer ALU for the datapath.
- Adds a valid/ready handshake, signed ops, signed branches and an iterative multiply.
- Single-cycle ops are registered and appear 1 cycle after accept; MUL is multi-cycle and back-pressures via o_ready.
- Flags signed overflow and illegal opcodes.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_mul_seq.sv | 60 ++++++
 rtl/alu_mc.sv | 152 +++++++++++++++
 tb/tb_alu_mc.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - 4-bit opcode encodings (OP_ADD .. OP_MUL, OP_ILL)
//   - FSM state encoding (ST_IDLE, ST_MUL)
//   - result-flag bundle (take / overflow / illegal) and its width
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_BNE  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_SLT  = 4'd10;
    localparam logic [3:0] OP_SLTU = 4'd11;
    localparam logic [3:0] OP_BLT  = 4'd12;
    localparam logic [3:0] OP_BGE  = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;
    localparam logic [3:0] OP_ILL  = 4'd15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam int FLAG_W = 3;

    typedef struct packed {
        logic take;
        logic overflow;
        logic illegal;
    } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, rst_n : shared clock / asynchronous active-low reset
//   start      : load a and b, clear accumulator and counter
//   a, b       : operands (sampled only on start)
//   busy       : a multiplication is in progress
//   done       : final iteration happens on the coming edge
//   product    : low DATA_W bits of a*b, valid while done is high
module alu_mul_seq #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] addend;

    assign addend = mplier[0] ? mcand : '0;
    // product is the accumulator including the current step, so the owner
    // can capture the finished result on the same edge as the last step
    assign product = acc + addend;
    assign done    = busy && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: parametrised integer ALU with valid/ready handshake.
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_valid / o_ready    : request handshake, accept on i_valid && o_ready
//   i_data_a, i_data_b   : operands
//   i_inst               : opcode (bits above [3:0] must be zero)
//   o_valid              : one-cycle pulse when result fields are new
//   o_data, o_take       : registered result and branch-taken flag
//   o_overflow           : signed overflow of ADD/SUB
//   o_illegal            : opcode was illegal
// Single-cycle ops answer one edge after accept; MUL takes DATA_W edges
// and holds o_ready low while it runs.
module alu_mc
    import alu_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int INST_W  = 4,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data_a,
    input  logic [DATA_W-1:0] i_data_b,
    input  logic [INST_W-1:0] i_inst,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_take,
    output logic              o_overflow,
    output logic              o_illegal
);

    state_t state;

    logic [3:0]               op;
    logic                     accept;
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic [DATA_W-1:0]        sum;
    logic [DATA_W-1:0]        diff;
    logic [SHAMT_W-1:0]       shamt;
    logic [DATA_W-1:0]        res_data;
    flags_t                   res_flags;

    logic              mul_start;
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    assign o_ready = (state == ST_IDLE);
    assign accept  = i_valid && o_ready;
    assign op      = i_inst[3:0];
    assign a_s     = $signed(i_data_a);
    assign b_s     = $signed(i_data_b);
    assign sum     = i_data_a + i_data_b;
    assign diff    = i_data_a - i_data_b;
    assign shamt   = i_data_b[SHAMT_W-1:0];

    always_comb begin
        res_data          = '0;
        res_flags         = '0;
        res_flags.illegal = (op == OP_ILL) || ((i_inst >> 4) != '0);
        case (op)
            OP_ADD: begin
                res_data = sum;
                res_flags.overflow = (i_data_a[DATA_W-1] == i_data_b[DATA_W-1]) &&
                                     (sum[DATA_W-1] != i_data_a[DATA_W-1]);
            end
            OP_SUB: begin
                res_data = diff;
                res_flags.overflow = (i_data_a[DATA_W-1] != i_data_b[DATA_W-1]) &&
                                     (diff[DATA_W-1] != i_data_a[DATA_W-1]);
            end
            OP_AND:  res_data = i_data_a & i_data_b;
            OP_OR:   res_data = i_data_a | i_data_b;
            OP_XOR:  res_data = i_data_a ^ i_data_b;
            OP_SLL:  res_data = i_data_a << shamt;
            OP_SRL:  res_data = i_data_a >> shamt;
            OP_SRA:  res_data = a_s >>> shamt;
            OP_SLT:  res_data = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: res_data = {{(DATA_W-1){1'b0}}, (i_data_a < i_data_b)};
            OP_BEQ:  res_flags.take = (i_data_a == i_data_b);
            OP_BNE:  res_flags.take = (i_data_a != i_data_b);
            OP_BLT:  res_flags.take = (a_s < b_s);
            OP_BGE:  res_flags.take = (a_s >= b_s);
            default: res_data = '0;
        endcase
    end

    assign mul_start = accept && !res_flags.illegal && (op == OP_MUL);

    alu_mul_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .start   (mul_start),
        .a       (i_data_a),
        .b       (i_data_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_take     <= 1'b0;
            o_overflow <= 1'b0;
            o_illegal  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (res_flags.illegal) begin
                            // o_data and o_take deliberately keep the last result
                            o_valid    <= 1'b1;
                            o_illegal  <= 1'b1;
                            o_overflow <= 1'b0;
                        end else if (op == OP_MUL) begin
                            state <= ST_MUL;
                        end else begin
                            o_valid    <= 1'b1;
                            o_data     <= res_data;
                            o_take     <= res_flags.take;
                            o_overflow <= res_flags.overflow;
                            o_illegal  <= 1'b0;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state      <= ST_IDLE;
                        o_valid    <= 1'b1;
                        o_data     <= mul_product;
                        o_take     <= 1'b0;
                        o_overflow <= 1'b0;
                        o_illegal  <= 1'b0;
                    end else if (!mul_busy) begin
                        // multiplier idle without a result: never strand the FSM
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

    localparam int DATA_W = 64;
    localparam int INST_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic [DATA_W-1:0] i_data_a = '0;
    logic [DATA_W-1:0] i_data_b = '0;
    logic [INST_W-1:0] i_inst = '0;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_take;
    logic              o_overflow;
    logic              o_illegal;

    int checks = 0;
    int errors = 0;

    alu_mc #(.DATA_W(DATA_W), .INST_W(INST_W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data_a   (i_data_a),
        .i_data_b   (i_data_b),
        .i_inst     (i_inst),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_take     (o_take),
        .o_overflow (o_overflow),
        .o_illegal  (o_illegal)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic              m_valid = 0;
    logic [DATA_W-1:0] m_data  = '0;
    logic              m_take  = 0;
    logic              m_ovf   = 0;
    logic              m_ill   = 0;
    int                m_left  = 0;   // edges until a pending product is due
    logic [DATA_W-1:0] m_prod  = '0;

    task automatic model_op(input logic [3:0] op, input logic [DATA_W-1:0] a, b,
                            output logic [DATA_W-1:0] d, output logic t, output logic v);
        logic signed [DATA_W:0]   wide;
        logic signed [DATA_W-1:0] sa, sb, sh;
        int                       amt;
        sa = a; sb = b; amt = int'(b[5:0]);
        d = '0; t = 0; v = 0;
        case (op)
            4'd0:  begin wide = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
                         d = wide[DATA_W-1:0]; v = (wide[DATA_W] != wide[DATA_W-1]); end
            4'd1:  begin wide = $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
                         d = wide[DATA_W-1:0]; v = (wide[DATA_W] != wide[DATA_W-1]); end
            4'd2:  d = a & b;
            4'd3:  d = a | b;
            4'd4:  d = a ^ b;
            4'd5:  d = a << amt;
            4'd6:  d = a >> amt;
            4'd7:  t = (a == b);
            4'd8:  t = (a != b);
            4'd9:  begin sh = sa >>> amt; d = sh; end
            4'd10: d = (sa < sb) ? 1 : 0;
            4'd11: d = (a < b) ? 1 : 0;
            4'd12: t = (sa < sb);
            4'd13: t = (sa >= sb);
            default: d = '0;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        logic [DATA_W-1:0] d;
        logic t, v;
        if (!rst_n) begin
            m_valid = 0; m_data = '0; m_take = 0; m_ovf = 0; m_ill = 0; m_left = 0;
        end else begin
            m_valid = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1; m_data = m_prod; m_take = 0; m_ovf = 0; m_ill = 0;
                end
            end else if (i_valid) begin
                if (i_inst == 4'd15) begin
                    m_valid = 1; m_ill = 1; m_ovf = 0;
                end else if (i_inst == 4'd14) begin
                    m_prod = i_data_a * i_data_b;
                    m_left = DATA_W;
                end else begin
                    model_op(i_inst, i_data_a, i_data_b, d, t, v);
                    m_valid = 1; m_data = d; m_take = t; m_ovf = v; m_ill = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        checks++;
        if ({o_ready, o_valid, o_data, o_take, o_overflow, o_illegal} !==
            {(m_left == 0), m_valid, m_data, m_take, m_ovf, m_ill}) begin
            errors++;
            $display("FAIL model t=%0t got rdy=%b vld=%b data=%h take=%b ovf=%b ill=%b want rdy=%b vld=%b data=%h take=%b ovf=%b ill=%b",
                     $time, o_ready, o_valid, o_data, o_take, o_overflow, o_illegal,
                     (m_left == 0), m_valid, m_data, m_take, m_ovf, m_ill);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        i_valid = 1; i_inst = op; i_data_a = a; i_data_b = b;
        @(posedge clk);
        @(negedge clk);
        i_valid = 0;
    endtask

    function automatic logic [DATA_W-1:0] rand_val();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 64'd1;
            2: return '1;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            4: return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int seen;
        repeat (3) @(negedge clk);
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_data", o_data, 64'd0);
        chk("reset_ready", 64'(o_ready), 64'd1);
        rst_n = 1;
        @(negedge clk);

        issue(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        chk("add_valid", 64'(o_valid), 64'd1);
        chk("add_data", o_data, 64'h8000_0000_0000_0000);
        chk("add_ovf", 64'(o_overflow), 64'd1);
        issue(4'd1, 64'd5, 64'd7);
        chk("sub_data", o_data, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_ovf", 64'(o_overflow), 64'd0);
        issue(4'd9, 64'h8000_0000_0000_0010, 64'h104);
        chk("sra_data", o_data, 64'hF800_0000_0000_0001);
        issue(4'd6, 64'h8000_0000_0000_0010, 64'h104);
        chk("srl_data", o_data, 64'h0800_0000_0000_0001);
        issue(4'd12, '1, 64'd1);
        chk("blt_take", 64'(o_take), 64'd1);
        chk("blt_data", o_data, 64'd0);
        issue(4'd13, '1, 64'd1);
        chk("bge_take", 64'(o_take), 64'd0);
        issue(4'd11, '1, 64'd1);
        chk("sltu_data", o_data, 64'd0);
        issue(4'd10, '1, 64'd1);
        chk("slt_data", o_data, 64'd1);

        // MUL with ignored mid-run request and a held request afterwards
        issue(4'd14, 64'd123456789, 64'd1000);
        for (int i = 0; i < 63; i++) begin
            chk("mul_ready_low", 64'(o_ready), 64'd0);
            if (i == 10) begin i_valid = 1; i_inst = 4'd0; i_data_a = 64'd9; i_data_b = 64'd9; end
            if (i == 11) i_valid = 0;
            if (i == 40) begin i_valid = 1; i_inst = 4'd0; i_data_a = 64'd1; i_data_b = 64'd2; end
            @(negedge clk);
        end
        n = 0;
        while (!o_valid && n < 10) begin @(negedge clk); n++; end
        chk("mul_valid", 64'(o_valid), 64'd1);
        chk("mul_data", o_data, 64'd123456789000);
        chk("mul_ready_back", 64'(o_ready), 64'd1);
        @(negedge clk);
        i_valid = 0;
        chk("held_add_valid", 64'(o_valid), 64'd1);
        chk("held_add_data", o_data, 64'd3);

        // illegal after a result of 42
        issue(4'd0, 64'd40, 64'd2);
        issue(4'd15, 64'd1, 64'd1);
        chk("ill_valid", 64'(o_valid), 64'd1);
        chk("ill_flag", 64'(o_illegal), 64'd1);
        chk("ill_data", o_data, 64'd42);
        chk("ill_take", 64'(o_take), 64'd0);
        @(negedge clk);
        chk("valid_pulse", 64'(o_valid), 64'd0);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            i_valid  = ($urandom_range(0, 9) < 7);
            i_inst   = 4'($urandom_range(0, 15));
            i_data_a = rand_val();
            i_data_b = ($urandom_range(0, 3) == 0) ? i_data_a : rand_val();
            @(negedge clk);
        end
        i_valid = 0;
        repeat (DATA_W + 2) @(negedge clk);

        // reset in the middle of a MUL
        issue(4'd14, 64'd77, 64'd99);
        repeat (19) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_valid", 64'(o_valid), 64'd0);
        chk("abort_data", o_data, 64'd0);
        chk("abort_flags", {61'd0, o_take, o_overflow, o_illegal}, 64'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("abort_ready", 64'(o_ready), 64'd1);
        seen = 0;
        repeat (DATA_W + 16) begin
            if (o_valid) seen++;
            @(negedge clk);
        end
        chk("abort_no_valid", 64'(seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
